// File: rtl/binary_mul_issue_ctrl.sv
// binary_mul_issue_ctrl: valid/ready issue and collect controller around a pipelined array multiplier
module binary_mul_issue_ctrl #(
    parameter int WIDTH = 4,
    parameter int LAT   = 5,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_en,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_p,
    output logic [CNT_W-1:0]   done_cnt
);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, HOLD, OUT} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          accept, handoff, fill_done;

    assign in_ready  = (state == IDLE) || (state == OUT && res_ready);
    assign accept    = in_valid && in_ready;
    assign handoff   = (state == OUT) && res_ready;
    assign fill_done = (state == HOLD) && (cnt == CW'(LAT));
    assign mul_en    = (state == HOLD);
    assign res_valid = (state == OUT);

    // next state: a same-edge handoff plus accept goes straight back to HOLD
    always_comb begin
        state_nx = state;
        if (accept) state_nx = HOLD;
        else if (handoff) state_nx = IDLE;
        else if (fill_done) state_nx = OUT;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // operand hold, fill counter, product capture and handoff counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a    <= '0;
            mul_b    <= '0;
            cnt      <= '0;
            res_p    <= '0;
            done_cnt <= '0;
        end else begin
            if (accept) begin
                mul_a <= in_a;
                mul_b <= in_b;
            end
            cnt <= accept ? '0 : (state == HOLD && !fill_done) ? cnt + 1'b1 : cnt;
            if (fill_done) res_p <= mul_p;
            if (handoff) done_cnt <= done_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_binary_mul_issue_ctrl.sv
// tb_binary_mul_issue_ctrl: scoreboard bench with a latency-modelled multiplier stand-in
module tb_binary_mul_issue_ctrl;
    localparam int WIDTH = 4;
    localparam int LAT   = 5;
    localparam int CNT_W = 8;

    logic             clk = 0;
    logic             rst_n = 0;
    logic             in_valid = 0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = 0, in_b = 0;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic             mul_en;
    logic [7:0]       mul_p;
    logic             res_valid;
    logic             res_ready = 1;
    logic [7:0]       res_p;
    logic [CNT_W-1:0] done_cnt;

    int checks = 0;
    int errors = 0;

    binary_mul_issue_ctrl #(.WIDTH(WIDTH), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en),
        .mul_p(mul_p), .res_valid(res_valid), .res_ready(res_ready),
        .res_p(res_p), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    // multiplier stand-in: product is only correct after LAT enabled edges, garbage before
    int en_cnt = 0;
    always @(posedge clk) en_cnt <= !mul_en ? 0 : (en_cnt < LAT ? en_cnt + 1 : en_cnt);
    assign mul_p = (en_cnt >= LAT) ? 8'(mul_a) * 8'(mul_b) : (8'(mul_a) * 8'(mul_b)) ^ 8'hA5;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model state
    logic [7:0]       q[$];
    int               cyc = 0;
    int               acc_cyc = 0;
    bit               inflight = 0;
    logic [WIDTH-1:0] ea = 0, eb = 0;
    logic [CNT_W-1:0] hs = 0;
    bit               rand_rr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: compare DUT against model away from the edge, then advance model for the coming edge
    always @(negedge clk) begin
        int  age;
        bit  exp_rv, exp_en;
        if (!rst_n) begin
            chk("reset_outs", {in_ready, res_valid, mul_en, done_cnt, res_p, mul_a, mul_b},
                {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 4'd0});
            q.delete();
            inflight = 0;
            hs = 0;
        end else begin
            age    = cyc - acc_cyc;
            exp_rv = inflight && age >= LAT + 1;
            exp_en = inflight && age < LAT + 1;
            chk("res_valid", res_valid, exp_rv);
            chk("mul_en", mul_en, exp_en);
            chk("in_ready", in_ready, !inflight || (exp_rv && res_ready));
            chk("done_cnt", done_cnt, hs);
            if (exp_en) chk("mul_ab_hold", {mul_a, mul_b}, {ea, eb});
            if (exp_rv) chk("res_p", res_p, q.size() ? q[0] : -1);
            if (res_valid && res_ready) begin
                if (q.size()) void'(q.pop_front());
                hs++;
                inflight = 0;
            end
            if (in_valid && in_ready) begin
                q.push_back(8'(in_a) * 8'(in_b));
                inflight = 1;
                acc_cyc  = cyc + 1;
                ea = in_a;
                eb = in_b;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rr) res_ready = 1'($urandom_range(0, 1));
    endtask

    // present an operand pair and wait for it to be accepted; leaves in_valid high
    task automatic send(input logic [3:0] a, input logic [3:0] b);
        bit ok = 0;
        in_valid = 1;
        in_a = a;
        in_b = b;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            tick();
        end
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: a=%0d b=%0d never accepted", a, b);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && (q.size() || res_valid); i++) tick();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1;
        repeat (10) tick();

        send(4'hF, 4'hF);
        in_valid = 0;
        drain();
        @(negedge clk);
        chk("single_done_cnt", done_cnt, 1);
        tick();

        res_ready = 0;
        send(4'd9, 4'd7);
        in_valid = 0;
        for (int i = 0; i < 20 && !res_valid; i++) tick();
        repeat (5) begin
            @(negedge clk);
            chk("bp_res_p", res_p, 63);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        res_ready = 1;
        drain();

        send(4'd3, 4'd5);
        send(4'd0, 4'd11);
        send(4'd12, 4'd10);
        in_valid = 0;
        drain();

        send(4'd6, 4'd6);
        in_valid = 0;
        repeat (2) tick();
        rst_n = 0;
        #1;
        chk("midhold_reset", {in_ready, res_valid, mul_en, done_cnt, res_p, mul_a, mul_b},
            {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 4'd0});
        repeat (2) tick();
        rst_n = 1;
        repeat (12) begin
            @(negedge clk);
            chk("no_ghost_result", res_valid, 0);
            tick();
        end

        rand_rr = 1;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                send(4'(a), 4'(b));
                in_valid = $urandom_range(0, 1) ? 1'b1 : 1'b0;
            end
        in_valid = 0;
        rand_rr = 0;
        res_ready = 1;
        drain();
        @(negedge clk);
        chk("exh_done_wrap", done_cnt, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
